alu_seq_core: RTL and testbench

- Parametrised, multi-cycle successor to the combinational ALU stage.
- Accepts one decoded operation (opcode, two operands, immediate, two destination indices) over a valid/ready handshake. Produces a double-width result (lo → Rdst1, hi → Rdst2) over a second valid/ready handshake.
- MUL and DIV are iterative (one bit per cycle); all other ops complete in one cycle.
- Sits between the decode/register-read stage and register-file writeback.

---
 rtl/alu_seq_core.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_alu_seq_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// Sequential ALU core: one-cycle arithmetic/logic ops plus iterative shift-add MUL and restoring DIV.
// Optional build macro ALU_FLAGS_EN adds the registered {Z,N,C,V} output out_flags.
module alu_seq_core #(
    parameter int WIDTH = 16,
    parameter int OPW   = 6,
    parameter int RAW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RAW-1:0]   in_rdst1,
    input  logic [RAW-1:0]   in_rdst2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [RAW-1:0]   out_rdst1,
    output logic [RAW-1:0]   out_rdst2,
    output logic             out_hi_we,
    output logic             out_illegal,
    output logic             out_dz
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]       out_flags
`endif
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    localparam logic [OPW-1:0] OP_MOVI = OPW'(5'd0);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(5'd1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'd4);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'd5);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'd6);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'd7);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'd8);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'd9);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5'd10);
    localparam logic [OPW-1:0] OP_NAND = OPW'(5'd11);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(5'd12);
    localparam logic [OPW-1:0] OP_XNOR = OPW'(5'd13);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'd14);
    localparam logic [OPW-1:0] OP_LLSH = OPW'(5'd15);
    localparam logic [OPW-1:0] OP_LRSH = OPW'(5'd16);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             multi_s;

    logic [WIDTH-1:0] res_lo_s;
    logic [WIDTH-1:0] res_hi_s;
    logic             hi_we_s;
    logic             ill_s;
    logic             dz_s;
    logic             shift_ovf_s;
    logic [SHW-1:0]   sh_amt_s;

    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] opa_r;
    logic             is_mul_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;

    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_lo_r;
    logic [WIDTH-1:0] out_hi_r;
    logic [RAW-1:0]   out_rdst1_r;
    logic [RAW-1:0]   out_rdst2_r;
    logic             out_hi_we_r;
    logic             out_illegal_r;
    logic             out_dz_r;

    // Only MUL and a non-zero-divisor DIV need the iterative datapath
    assign multi_s     = (in_op == OP_MUL) || ((in_op == OP_DIV) && (in_a != {WIDTH{1'b0}}));
    assign shift_ovf_s = |in_a[WIDTH-1:SHW];
    assign sh_amt_s    = in_a[SHW-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and accept strobe
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    if (multi_s) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Single-cycle result decode straight from the offered operands
    always_comb begin
        res_lo_s = {WIDTH{1'b0}};
        res_hi_s = {WIDTH{1'b0}};
        hi_we_s  = 1'b0;
        ill_s    = 1'b0;
        dz_s     = 1'b0;
        case (in_op)
            OP_MOVI: res_lo_s = in_imm;
            OP_MOV:  res_lo_s = in_a;
            OP_ADD:  res_lo_s = in_b + in_a;
            OP_SUB:  res_lo_s = in_b - in_a;
            OP_NEG:  res_lo_s = {WIDTH{1'b0}} - in_a;
            OP_MUL:  hi_we_s  = 1'b1;
            OP_DIV: begin
                hi_we_s = 1'b1;
                if (in_a == {WIDTH{1'b0}}) begin
                    res_lo_s = {WIDTH{1'b1}};
                    res_hi_s = in_b;
                    dz_s     = 1'b1;
                end else begin
                    dz_s     = 1'b0;
                end
            end
            OP_OR:   res_lo_s = in_b | in_a;
            OP_XOR:  res_lo_s = in_b ^ in_a;
            OP_NAND: res_lo_s = ~(in_b & in_a);
            OP_NOR:  res_lo_s = ~(in_b | in_a);
            OP_XNOR: res_lo_s = ~(in_b ^ in_a);
            OP_NOT:  res_lo_s = ~in_a;
            OP_LLSH: begin
                if (shift_ovf_s) begin
                    res_lo_s = {WIDTH{1'b0}};
                end else begin
                    res_lo_s = in_b << sh_amt_s;
                end
            end
            OP_LRSH: begin
                if (shift_ovf_s) begin
                    res_lo_s = {WIDTH{1'b0}};
                end else begin
                    res_lo_s = in_b >> sh_amt_s;
                end
            end
            default: ill_s = 1'b1;
        endcase
    end

    // One iteration step: acc_hi holds partial product / remainder, acc_lo the multiplier / quotient
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opa_r});
        if (is_mul_r) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end else if (div_ge_s) begin
            step_hi_s = WIDTH'(div_shift_s - {1'b0, opa_r});
            step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            step_hi_s = div_shift_s[WIDTH-1:0];
            step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Capture on accept, iterate in EXEC, register the result words and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            out_lo_r      <= {WIDTH{1'b0}};
            out_hi_r      <= {WIDTH{1'b0}};
            out_rdst1_r   <= {RAW{1'b0}};
            out_rdst2_r   <= {RAW{1'b0}};
            out_hi_we_r   <= 1'b0;
            out_illegal_r <= 1'b0;
            out_dz_r      <= 1'b0;
            acc_hi_r      <= {WIDTH{1'b0}};
            acc_lo_r      <= {WIDTH{1'b0}};
            opa_r         <= {WIDTH{1'b0}};
            is_mul_r      <= 1'b0;
            cnt_r         <= {CW{1'b0}};
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            if (accept_s) begin
                out_rdst1_r   <= in_rdst1;
                out_rdst2_r   <= in_rdst2;
                out_hi_we_r   <= hi_we_s;
                out_illegal_r <= ill_s;
                out_dz_r      <= dz_s;
                opa_r         <= in_a;
                is_mul_r      <= (in_op == OP_MUL);
                cnt_r         <= CNT_INIT;
                acc_hi_r      <= {WIDTH{1'b0}};
                acc_lo_r      <= in_b;
                if (!multi_s) begin
                    out_lo_r <= res_lo_s;
                    out_hi_r <= res_hi_s;
                end
            end else if (state_r == ST_EXEC) begin
                acc_hi_r <= step_hi_s;
                acc_lo_r <= step_lo_s;
                cnt_r    <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    out_lo_r <= step_lo_s;
                    out_hi_r <= step_hi_s;
                end
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_lo      = out_lo_r;
    assign out_hi      = out_hi_r;
    assign out_rdst1   = out_rdst1_r;
    assign out_rdst2   = out_rdst2_r;
    assign out_hi_we   = out_hi_we_r;
    assign out_illegal = out_illegal_r;
    assign out_dz      = out_dz_r;

`ifdef ALU_FLAGS_EN
    logic [3:0] out_flags_r;

    function automatic logic [3:0] calc_flags(input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] lo,
                                              input logic [WIDTH-1:0] hi);
        logic [WIDTH:0] sum;
        logic           z;
        logic           n;
        logic           c;
        logic           v;
        sum = {1'b0, b} + {1'b0, a};
        z   = (lo == {WIDTH{1'b0}});
        n   = lo[WIDTH-1];
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (lo[WIDTH-1] != b[WIDTH-1]);
            end
            OP_SUB: begin
                c = (b >= a);
                v = (a[WIDTH-1] != b[WIDTH-1]) && (lo[WIDTH-1] != b[WIDTH-1]);
            end
            OP_NEG:  v = a[WIDTH-1] & lo[WIDTH-1];
            OP_MUL:  z = ({hi, lo} == {(2*WIDTH){1'b0}});
            default: c = 1'b0;
        endcase
        return {z, n, c, v};
    endfunction

    // Flags follow the result words onto the same edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flags_r <= 4'd0;
        end else if (accept_s && !multi_s) begin
            out_flags_r <= calc_flags(in_op, in_a, in_b, res_lo_s, res_hi_s);
        end else if ((state_r == ST_EXEC) && (cnt_r == CNT_ONE)) begin
            out_flags_r <= calc_flags(is_mul_r ? OP_MUL : OP_DIV, opa_r, acc_lo_r, step_lo_s, step_hi_s);
        end
    end

    assign out_flags = out_flags_r;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized self-checking bench for alu_seq_core against a plain-arithmetic reference model.
// Optional flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_imm;
    logic [4:0]  in_rdst1;
    logic [4:0]  in_rdst2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_lo;
    logic [15:0] out_hi;
    logic [4:0]  out_rdst1;
    logic [4:0]  out_rdst2;
    logic        out_hi_we;
    logic        out_illegal;
    logic        out_dz;
`ifdef ALU_FLAGS_EN
    logic [3:0]  out_flags;
`endif

    int total = 0;
    int bad   = 0;

    alu_seq_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_imm      (in_imm),
        .in_rdst1    (in_rdst1),
        .in_rdst2    (in_rdst2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lo      (out_lo),
        .out_hi      (out_hi),
        .out_rdst1   (out_rdst1),
        .out_rdst2   (out_rdst2),
        .out_hi_we   (out_hi_we),
        .out_illegal (out_illegal),
        .out_dz      (out_dz)
`ifdef ALU_FLAGS_EN
        ,
        .out_flags   (out_flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference results straight from the opcode table
    function automatic void ref_model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] imm, output logic [15:0] lo, output logic [15:0] hi,
                                      output logic hwe, output logic ill, output logic dz);
        logic [31:0] p;
        lo = 16'h0; hi = 16'h0; hwe = 1'b0; ill = 1'b0; dz = 1'b0;
        case (op)
            6'd0:  lo = imm;
            6'd1:  lo = a;
            6'd4:  lo = b + a;
            6'd5:  lo = b - a;
            6'd6:  lo = 16'h0 - a;
            6'd7:  begin p = a * b; lo = p[15:0]; hi = p[31:16]; hwe = 1'b1; end
            6'd8:  begin
                hwe = 1'b1;
                if (a == 16'h0) begin lo = 16'hFFFF; hi = b; dz = 1'b1; end
                else begin lo = b / a; hi = b % a; end
            end
            6'd9:  lo = b | a;
            6'd10: lo = b ^ a;
            6'd11: lo = ~(b & a);
            6'd12: lo = ~(b | a);
            6'd13: lo = ~(b ^ a);
            6'd14: lo = ~a;
            6'd15: lo = (a >= 16'd16) ? 16'h0 : (b << a);
            6'd16: lo = (a >= 16'd16) ? 16'h0 : (b >> a);
            default: ill = 1'b1;
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] ref_flags(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] lo, input logic [15:0] hi);
        int s;
        logic z, n, c, v;
        z = (lo == 16'h0); n = lo[15]; c = 1'b0; v = 1'b0;
        if (op == 6'd4) begin
            c = (int'(a) + int'(b)) > 65535;
            s = int'($signed(a)) + int'($signed(b));
            v = (s > 32767) || (s < -32768);
        end else if (op == 6'd5) begin
            c = (b >= a);
            s = int'($signed(b)) - int'($signed(a));
            v = (s > 32767) || (s < -32768);
        end else if (op == 6'd6) begin
            v = (a == 16'h8000);
        end else if (op == 6'd7) begin
            z = (lo == 16'h0) && (hi == 16'h0);
        end
        return {z, n, c, v};
    endfunction
`endif

    // Offer one operation, check latency, result, backpressure hold and return to idle
    task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] imm, input int hold);
        logic [15:0] elo, ehi;
        logic        ehwe, eill, edz;
        logic [4:0]  r1, r2;
        int          lat, elat;
        ref_model(op, a, b, imm, elo, ehi, ehwe, eill, edz);
        elat = ((op == 6'd7) || ((op == 6'd8) && (a != 16'h0))) ? 17 : 1;
        r1 = 5'($urandom_range(0, 31));
        r2 = 5'($urandom_range(0, 31));
        @(negedge clk);
        check_val("ready_idle", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_imm = imm; in_rdst1 = r1; in_rdst2 = r2;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_a = 16'($urandom); in_b = 16'($urandom); in_imm = 16'($urandom);
        in_op = 6'($urandom); in_rdst1 = 5'($urandom); in_rdst2 = 5'($urandom);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
            check_val("ready_busy", in_ready, 0);
        end
        check_val("latency", lat, elat);
        check_val("lo", out_lo, elo);
        check_val("hi", out_hi, ehi);
        check_val("hi_we", out_hi_we, ehwe);
        check_val("illegal", out_illegal, eill);
        check_val("dz", out_dz, edz);
        check_val("rdst1", out_rdst1, r1);
        check_val("rdst2", out_rdst2, r2);
`ifdef ALU_FLAGS_EN
        check_val("flags", out_flags, ref_flags(op, a, b, elo, ehi));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_lo", out_lo, elo);
            check_val("hold_hi", out_hi, ehi);
            check_val("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("post_valid", out_valid, 0);
        check_val("post_ready", in_ready, 1);
    endtask

    // Asynchronous reset in the middle of a multiply must discard it
    task automatic reset_mid_mul();
        @(negedge clk);
        in_valid = 1'b1; in_op = 6'd7; in_a = 16'h1234; in_b = 16'h0100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_valid", out_valid, 0);
        check_val("rst_lo", out_lo, 0);
        check_val("rst_hi", out_hi, 0);
        check_val("rst_hi_we", out_hi_we, 0);
        check_val("rst_rdst1", out_rdst1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check_val("rst_no_stale", out_valid, 0);
            check_val("rst_ready", in_ready, 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 6'd0; in_a = 16'h0; in_b = 16'h0; in_imm = 16'h0; in_rdst1 = 5'd0; in_rdst2 = 5'd0;
        repeat (3) @(negedge clk);
        check_val("reset_valid", out_valid, 0);
        check_val("reset_ready", in_ready, 1);
        check_val("reset_lo", out_lo, 0);
        check_val("reset_hi", out_hi, 0);
        check_val("reset_hi_we", out_hi_we, 0);
        check_val("reset_illegal", out_illegal, 0);
        check_val("reset_dz", out_dz, 0);
`ifdef ALU_FLAGS_EN
        check_val("reset_flags", out_flags, 0);
`endif
        rst_n = 1'b1;

        run_op(6'd4,  16'h0001, 16'h1234, 16'h0, 0);
        run_op(6'd5,  16'd7,    16'd5,    16'h0, 0);
        run_op(6'd7,  16'h1234, 16'h0100, 16'h0, 0);
        run_op(6'd8,  16'd7,    16'd100,  16'h0, 1);
        run_op(6'd8,  16'h0000, 16'h00AB, 16'h0, 0);
        run_op(6'd10, 16'h5A5A, 16'h0FF0, 16'h0, 5);
        run_op(6'd3,  16'h1111, 16'h2222, 16'h3333, 0);
        reset_mid_mul();
        run_op(6'd15, 16'd16,   16'h0001, 16'h0, 0);
        run_op(6'd15, 16'd15,   16'h0001, 16'h0, 0);
        run_op(6'd16, 16'hFFFF, 16'h8000, 16'h0, 0);
        run_op(6'd16, 16'd15,   16'h8000, 16'h0, 0);
        run_op(6'd6,  16'h8000, 16'h0,    16'h0, 0);
        run_op(6'd0,  16'h0,    16'h0,    16'hBEEF, 0);
        run_op(6'd7,  16'hFFFF, 16'hFFFF, 16'h0, 2);
        run_op(6'd8,  16'hFFFF, 16'hFFFE, 16'h0, 0);
        run_op(6'd8,  16'h0001, 16'hFFFF, 16'h0, 0);
        run_op(6'd63, 16'h0,    16'h0,    16'h0, 0);

        for (int i = 0; i < 200; i++) begin
            logic [5:0]  op;
            logic [15:0] a;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 18));
            case ($urandom_range(0, 3))
                0:       a = 16'h0;
                1:       a = 16'($urandom_range(0, 20));
                default: a = 16'($urandom);
            endcase
            run_op(op, a, 16'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
